// File: rtl/fp_divider.sv
// fp_divider: iterative restoring divider for the 24-bit float word
// {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]} with a hidden leading 1 and bias BIAS.
// One quotient bit is produced per cycle; the fraction is truncated.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   in_a_i, in_b_i    dividend / divisor words
//   in_valid_i        operands present
//   in_ready_o        idle and out of reset; an operation can be accepted
//   out_result_o      quotient word
//   out_valid_o       result and flags valid (held until out_ready_i)
//   out_ready_i       consumer accepts the result
//   out_overflow_o    normalised exponent above the representable range (saturated result)
//   out_underflow_o   normalised exponent below zero (result flushed to signed zero)
//   out_div_by_zero_o divisor was zero (saturated result)
module fp_divider #(
    parameter int unsigned EXP_W  = 7,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned BIAS   = 63
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [EXP_W+FRAC_W:0]       in_a_i,
    input  logic [EXP_W+FRAC_W:0]       in_b_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic [EXP_W+FRAC_W:0]       out_result_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        out_overflow_o,
    output logic                        out_underflow_o,
    output logic                        out_div_by_zero_o
);

    localparam int unsigned WordW = 1 + EXP_W + FRAC_W;
    localparam int unsigned MantW = FRAC_W + 1;  // mantissa with hidden 1
    localparam int unsigned QW    = FRAC_W + 2;  // quotient in [2^(FRAC_W), 2^(FRAC_W+2))
    localparam int unsigned RemW  = FRAC_W + 2;  // remainder needs one bit over the mantissa
    localparam int unsigned EW    = EXP_W + 2;   // signed exponent with headroom
    localparam int unsigned CntW  = $clog2(QW);

    localparam logic signed [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StNormalise,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [RemW-1:0]       rem_q, rem_d;
    logic [MantW-1:0]      div_q, div_d;
    logic [QW-1:0]         q_q, q_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [WordW-1:0]      result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  dbz_q, dbz_d;

    // Operand field decode
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [FRAC_W-1:0] a_frac, b_frac;
    logic              a_zero, b_zero, accept;
    logic signed [EW-1:0] exp_in;

    assign a_exp  = in_a_i[WordW-2 -: EXP_W];
    assign b_exp  = in_b_i[WordW-2 -: EXP_W];
    assign a_frac = in_a_i[FRAC_W-1:0];
    assign b_frac = in_b_i[FRAC_W-1:0];
    assign a_zero = (in_a_i[WordW-2:0] == '0);
    assign b_zero = (in_b_i[WordW-2:0] == '0);
    assign exp_in = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + $signed(EW'(BIAS));

    assign in_ready_o = (state_q == StIdle) && rst_ni;
    assign accept     = in_valid_i && in_ready_o;

    // Restoring step: compare, conditionally subtract, shift
    logic            rem_ge;
    logic [RemW-1:0] rem_sub;

    assign rem_ge  = (rem_q >= {1'b0, div_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    // Normalisation of the finished quotient
    logic [FRAC_W-1:0]    norm_frac;
    logic signed [EW-1:0] norm_exp;

    always_comb begin
        if (q_q[QW-1]) begin
            norm_frac = q_q[QW-2:1];
            norm_exp  = exp_q;
        end else begin
            norm_frac = q_q[FRAC_W-1:0];
            norm_exp  = exp_q - $signed(EW'(1));
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (a_zero || b_zero) ? StDone : StDivide;
                end
            end
            StDivide: begin
                if (cnt_q == '0) begin
                    state_d = StNormalise;
                end
            end
            StNormalise: state_d = StDone;
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        div_d    = div_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sign_d = in_a_i[WordW-1] ^ in_b_i[WordW-1];
                    exp_d  = exp_in;
                    rem_d  = {1'b0, 1'b1, a_frac};
                    div_d  = {1'b1, b_frac};
                    q_d    = '0;
                    cnt_d  = CntW'(QW - 1);
                    // Zero divisor takes priority over a zero dividend
                    if (b_zero) begin
                        result_d = {sign_d, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
                        dbz_d    = 1'b1;
                    end else if (a_zero) begin
                        result_d = {sign_d, {(WordW-1){1'b0}}};
                    end
                end
            end
            StDivide: begin
                q_d[cnt_q] = rem_ge;
                rem_d      = {rem_sub[RemW-2:0], 1'b0};
                cnt_d      = cnt_q - 1'b1;
            end
            StNormalise: begin
                if (norm_exp > ExpMax) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
                    ovf_d    = 1'b1;
                end else if (norm_exp < 0) begin
                    result_d = {sign_q, {(WordW-1){1'b0}}};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, norm_exp[EXP_W-1:0], norm_frac};
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    dbz_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dbz_q    <= dbz_d;
        end
    end

    // Outputs
    always_comb begin
        out_valid_o       = (state_q == StDone);
        out_result_o      = result_q;
        out_overflow_o    = ovf_q;
        out_underflow_o   = unf_q;
        out_div_by_zero_o = dbz_q;
    end

endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider: table of hand-computed vectors plus
// sequences for backpressure and reset during an operation.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] in_a, in_b;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_result;
    logic        out_valid;
    logic        out_ready;
    logic        out_overflow, out_underflow, out_div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_divider dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .in_a_i           (in_a),
        .in_b_i           (in_b),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .out_result_o     (out_result),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_overflow_o   (out_overflow),
        .out_underflow_o  (out_underflow),
        .out_div_by_zero_o(out_div_by_zero)
    );

    typedef struct {
        string       name;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] res;
        logic        ovf;
        logic        unf;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int NVec = 15;
    vec_t vecs[NVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Issue one operation from idle; return when out_valid is seen (or budget expires).
    task automatic do_op(input logic [23:0] a, input logic [23:0] b, input string name,
                         output int lat, output bit busy_ok);
        chk({name, " in_ready before"}, 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 40) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: out_valid not seen within 40 cycles", name);
        end
    endtask

    initial begin
        int  lat;
        bit  busy_ok;
        int  pulses;
        logic [23:0] held;

        vecs[0]  = '{"unit",        24'h3F0000, 24'h3F0000, 24'h3F0000, 0, 0, 0, 19};
        vecs[1]  = '{"3/-1.5",      24'h408000, 24'hBF8000, 24'hC00000, 0, 0, 0, 19};
        vecs[2]  = '{"1/1.5",       24'h3F0000, 24'h3F8000, 24'h3E5555, 0, 0, 0, 19};
        vecs[3]  = '{"ovf range",   24'h7F0000, 24'h010000, 24'h7FFFFF, 1, 0, 0, 19};
        vecs[4]  = '{"unf range",   24'h010000, 24'h7F0000, 24'h000000, 0, 1, 0, 19};
        vecs[5]  = '{"div zero",    24'h3F0000, 24'h800000, 24'hFFFFFF, 0, 0, 1, 0};
        vecs[6]  = '{"zero a",      24'h000000, 24'h3F0000, 24'h000000, 0, 0, 0, 0};
        vecs[7]  = '{"-zero a",     24'h800000, 24'h3F0000, 24'h800000, 0, 0, 0, 0};
        vecs[8]  = '{"1/0.5",       24'h3F0000, 24'h3E0000, 24'h400000, 0, 0, 0, 19};
        vecs[9]  = '{"3.5/1.5",     24'h40C000, 24'h3F8000, 24'h402AAA, 0, 0, 0, 19};
        vecs[10] = '{"exp 127",     24'h7F0000, 24'h3F0000, 24'h7F0000, 0, 0, 0, 19};
        vecs[11] = '{"exp 128",     24'h7F0000, 24'h3E0000, 24'h7FFFFF, 1, 0, 0, 19};
        vecs[12] = '{"exp 0",       24'h010000, 24'h3F8000, 24'h005555, 0, 0, 0, 19};
        vecs[13] = '{"exp -1",      24'h000001, 24'h3F8000, 24'h000000, 0, 1, 0, 19};
        vecs[14] = '{"neg/neg",     24'hBF0000, 24'hBF0000, 24'h3F0000, 0, 0, 0, 19};

        rst_n     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst out_result", 32'(out_result), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst flags", 32'({out_overflow, out_underflow, out_div_by_zero}), 32'd0);
        chk("rst in_ready low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready after release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVec; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].name, lat, busy_ok);
            chk({vecs[i].name, " result"}, 32'(out_result), 32'(vecs[i].res));
            chk({vecs[i].name, " ovf"}, 32'(out_overflow), 32'(vecs[i].ovf));
            chk({vecs[i].name, " unf"}, 32'(out_underflow), 32'(vecs[i].unf));
            chk({vecs[i].name, " dbz"}, 32'(out_div_by_zero), 32'(vecs[i].dbz));
            chk({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
            chk({vecs[i].name, " in_ready low while busy"}, 32'(busy_ok), 32'd1);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " valid drop"}, 32'(out_valid), 32'd0);
            chk({vecs[i].name, " flags clear"},
                32'({out_overflow, out_underflow, out_div_by_zero}), 32'd0);
        end

        // Backpressure: 1.5/1.0 held for 5 cycles
        out_ready = 1'b0;
        do_op(24'h3F8000, 24'h3F0000, "bp", lat, busy_ok);
        chk("bp result", 32'(out_result), 32'h3F8000);
        held = 24'h3F8000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp hold result", 32'(out_result), 32'(held));
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp release valid", 32'(out_valid), 32'd0);

        // Reset during DIVIDE iteration 7
        in_a     = 24'h3F0000;
        in_b     = 24'h3F8000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_result", 32'(out_result), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst flags", 32'({out_overflow, out_underflow, out_div_by_zero}), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        chk("no valid after reset", 32'(pulses), 32'd0);
        do_op(24'h3F0000, 24'h3F0000, "post-rst unit", lat, busy_ok);
        chk("post-rst result", 32'(out_result), 32'h3F0000);
        chk("post-rst latency", 32'(lat), 32'd19);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
# fp_divider

- Iterative floating-point divider for the 24-bit format used by the multiplier datapath: 1 sign bit, 7-bit exponent (bias 63), 16-bit fraction with a hidden leading 1.
- Computes a/b with a restoring shift-subtract loop, one quotient bit per cycle.
- Uses valid/ready handshakes on both sides.
- Sits beside the multiplier pipeline as the inverse operation, and shares its word layout and its overflow/underflow flag semantics.

## Interface
- EXP_W, 7: exponent width; the word layout is {sign, exp[22:16], frac[15:0]}.
- FRAC_W, 16: fraction width, excluding the hidden 1.
- BIAS, 63: exponent offset.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately when low.
- in_a  in  24  dividend word.
- in_b  in  24  divisor word.
- in_valid  in  1  operands are present.
- in_ready  out  1  block can accept an operation; equals (state==IDLE) && rst.
- out_result  out  24  quotient word.
- out_valid  out  1  out_result and the flags are valid.
- out_ready  in  1  consumer accepts the result.
- out_overflow  out  1  biased result exponent > 127.
- out_underflow  out  1  biased result exponent < 0.
- out_div_by_zero  out  1  divisor is zero.

## Operation
- Zero encoding: exp==0 and frac==0, either sign.
- States: IDLE, DIVIDE, NORMALISE, DONE.
- IDLE: on an edge with in_valid && in_ready, latch:
  - sign = a[23]^b[23];
  - e = a.exp - b.exp + 63, as a signed 9-bit value;
  - rem = {1,a.frac} (18 bits);
  - div = {1,b.frac};
  - cnt = 17.
- Fast paths taken from IDLE, both going directly to DONE with the result registered on the accept edge:
  - b is zero: result {sign,7'h7F,16'hFFFF}, out_div_by_zero=1.
  - a is zero and b is nonzero: result {sign,23'b0}, no flags.
- Otherwise the next state is DIVIDE.
- DIVIDE, each cycle:
  - if rem >= div, then rem -= div and q[cnt]=1; otherwise q[cnt]=0;
  - then rem <<= 1 and cnt -= 1;
  - after the cnt==0 iteration, go to NORMALISE.
- Result of the loop: q = floor({1,fa}*2^17 / {1,fb}), in the range [2^16, 2^18).
- NORMALISE:
  - if q[17]=1: frac = q[16:1], exp = e;
  - else: frac = q[15:0], exp = e-1;
  - the fraction is truncated, with no rounding.
- Flags from the normalised exp:
  - exp > 127: out_overflow=1, result {sign,7'h7F,16'hFFFF};
  - exp < 0: out_underflow=1, result {sign,23'b0}.
- At most one flag is ever set.
- DONE:
  - out_valid=1; out_result and the flags are held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
- in_ready is 0 outside IDLE; in_valid is ignored while busy.

## Timing
- Reset values: out_result=0, out_valid=0, all flags=0, state=IDLE, in_ready=0 while rst is low and 1 after release.
- Normal latency: accept on edge E0, iterations on E1..E18, NORMALISE registers the outputs on E19. out_valid is high from E19 on.
- Fast-path latency: out_valid is high from E0, the accept edge itself.
- out_valid && out_ready at edge Ek: out_valid is low after Ek and in_ready is high after Ek. The earliest next accept is Ek+1. Minimum period is 21 cycles per operation.
- Backpressure: out_result and the flags must not change while out_valid=1 and out_ready=0.
- Reset asserted mid-operation (any state): immediate return to reset values. The partial result is discarded, and no out_valid pulse appears after release.
- Flags are valid only while out_valid=1; they clear to 0 when DONE is left.

## Test plan
- Unit division: a=0x3F0000, b=0x3F0000, out_ready=1. Require out_result=0x3F0000 with no flags, out_valid rising exactly 19 cycles after the accept edge, and in_ready=0 throughout.
- Equal mantissas with a sign change: 3.0/-1.5, i.e. a=0x408000, b=0xBF8000. Require out_result=0xC00000 (-2.0).
- Normalise shift path: 1.0/1.5, i.e. a=0x3F0000, b=0x3F8000. Require out_result=0x3E5555 (truncated 2/3), with q[17]=0 internally.
- Range limits:
  - a=0x7F0000, b=0x010000: out_result=0x7FFFFF, out_overflow=1.
  - a=0x010000, b=0x7F0000: out_result=0x000000, out_underflow=1.
- Divide by zero: a=0x3F0000, b=0x800000. Require out_result=0xFFFFFF, out_div_by_zero=1, out_valid high after the accept edge (no DIVIDE cycles).
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after out_valid rises. Require outputs stable and in_ready=0; release, then require in_ready=1 on the next cycle.
  - Start an operation and pull rst low during DIVIDE iteration 7. Require all outputs at reset values immediately. After release, an operation 0x3F0000/0x3F0000 completes correctly.
